// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - sequential grant holder and round-robin priority owner for a prefix arbiter
module rr_grant_ctrl #(
  parameter int arbiter_width = 8,
  parameter int hold_max      = 16,
  parameter int owner_w       = $clog2(arbiter_width)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [arbiter_width-1:0] i_req,
  input  logic [arbiter_width-1:0] i_done,
  input  logic [arbiter_width-1:0] i_grant,
  input  logic                     i_ag,
  output logic [arbiter_width-1:0] o_prior,
  output logic [arbiter_width-1:0] o_grant_q,
  output logic [owner_w-1:0]       o_owner,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic                     o_err
);

  localparam int cnt_w = (hold_max > 0) ? $clog2(hold_max + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'((hold_max > 0) ? hold_max - 1 : 0);
  localparam logic [cnt_w-1:0] cnt_sat  = '1;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_busy = 1'b1;

  logic [0:0]               state;
  logic [cnt_w-1:0]         cnt;
  logic                     grant_onehot;
  logic                     grant_in_req;
  logic                     accept;
  logic                     malformed;
  logic [owner_w-1:0]       grant_idx;
  logic                     rel_done;
  logic                     rel_drop;
  logic                     rel_tmo;
  logic                     release_now;
  logic [arbiter_width-1:0] prior_rot;

  always_comb begin
    grant_onehot = (i_grant != '0) &&
                   ((i_grant & (i_grant - arbiter_width'(1))) == '0);
    grant_in_req = (i_grant & i_req) != '0;
    accept       = i_ag && grant_onehot && grant_in_req;
    malformed    = i_ag && !accept;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < arbiter_width; i++) begin
      if (i_grant[i]) grant_idx = owner_w'(i);
    end
  end

  // Release qualifiers only look at the owner's lines; other requesters are ignored while BUSY.
  always_comb begin
    rel_done    = i_done[o_owner];
    rel_drop    = !i_req[o_owner];
    rel_tmo     = (hold_max != 0) && (cnt == cnt_last);
    release_now = rel_done || rel_drop || rel_tmo;
  end

  always_comb begin
    prior_rot = '0;
    for (int i = 0; i < arbiter_width; i++) begin
      prior_rot[(i + 1) % arbiter_width] = o_grant_q[i];
    end
  end

  assign o_busy = (state == st_busy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= st_idle;
      cnt       <= '0;
      o_prior   <= arbiter_width'(1);
      o_grant_q <= '0;
      o_owner   <= '0;
      o_timeout <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        st_idle: begin
          if (accept) begin
            o_grant_q <= i_grant;
            o_owner   <= grant_idx;
            cnt       <= '0;
            state     <= st_busy;
          end else if (malformed) begin
            o_err <= 1'b1;
          end
        end
        st_busy: begin
          if (release_now) begin
            o_grant_q <= '0;
            o_prior   <= prior_rot;
            state     <= st_idle;
            o_timeout <= rel_tmo && !rel_done && !rel_drop;
          end else if (cnt != cnt_sat) begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - directed self-checking bench for rr_grant_ctrl with hold_max=4
module tb_rr_grant_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req = '0;
  logic [W-1:0] done = '0;
  logic [W-1:0] man_grant = '0;
  logic         man_ag = 1'b0;
  logic         model_en = 1'b0;
  logic [W-1:0] arb_grant;
  logic [W-1:0] grant;
  logic         ag;
  logic [W-1:0] prior;
  logic [W-1:0] grant_q;
  logic [2:0]   owner;
  logic         busy;
  logic         timeout;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  rr_grant_ctrl #(.arbiter_width(W), .hold_max(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_done    (done),
    .i_grant   (grant),
    .i_ag      (ag),
    .o_prior   (prior),
    .o_grant_q (grant_q),
    .o_owner   (owner),
    .o_busy    (busy),
    .o_timeout (timeout),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  // Ideal round-robin arbiter: first requester at or after the priority position.
  always_comb begin
    int p;
    p = 0;
    for (int i = 0; i < W; i++) if (prior[i]) p = i;
    arb_grant = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (req[(p + k) % W]) begin
        arb_grant = '0;
        arb_grant[(p + k) % W] = 1'b1;
      end
    end
  end

  assign grant = model_en ? arb_grant : man_grant;
  assign ag    = model_en ? (arb_grant != '0) : man_ag;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_g;

    // Power-on reset
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_prior", prior, 8'h01);
    chk("rst_grant_q", grant_q, 8'h00);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err, 0);

    // Basic grant/release
    req = 8'h24; man_grant = 8'h04; man_ag = 1'b1;
    tick();
    chk("basic_grant_q", grant_q, 8'h04);
    chk("basic_owner", owner, 2);
    chk("basic_busy", busy, 1);
    chk("basic_prior_held", prior, 8'h01);
    man_ag = 1'b0; man_grant = 8'h00; done = 8'h04;
    tick();
    done = 8'h00;
    chk("basic_rel_grant_q", grant_q, 8'h00);
    chk("basic_rel_prior", prior, 8'h08);
    chk("basic_rel_busy", busy, 0);
    chk("basic_rel_owner_kept", owner, 2);

    // Owner 7, non-owner done ignored, then request drop wraps priority
    req = 8'h80; man_grant = 8'h80; man_ag = 1'b1;
    tick();
    chk("wrap_owner", owner, 7);
    man_ag = 1'b0; man_grant = 8'h00; done = 8'h01;
    tick();
    done = 8'h00;
    chk("wrap_nonowner_done_busy", busy, 1);
    chk("wrap_nonowner_done_grant", grant_q, 8'h80);
    req = 8'h00;
    tick();
    chk("wrap_drop_busy", busy, 0);
    chk("wrap_drop_prior", prior, 8'h01);
    chk("wrap_drop_timeout", timeout, 0);

    // Timeout after exactly 4 BUSY cycles
    req = 8'h08; man_grant = 8'h08; man_ag = 1'b1;
    tick();
    man_ag = 1'b0; man_grant = 8'h00;
    chk("tmo_busy_c1", busy, 1);
    repeat (3) tick();
    chk("tmo_busy_c4", busy, 1);
    chk("tmo_no_early_pulse", timeout, 0);
    tick();
    chk("tmo_rel_busy", busy, 0);
    chk("tmo_pulse", timeout, 1);
    chk("tmo_prior", prior, 8'h10);
    tick();
    chk("tmo_pulse_one_cycle", timeout, 0);

    // Done in the 4th cycle wins over timeout
    man_grant = 8'h08; man_ag = 1'b1;
    tick();
    man_ag = 1'b0; man_grant = 8'h00;
    repeat (3) tick();
    done = 8'h08;
    tick();
    done = 8'h00;
    chk("tmo_done_busy", busy, 0);
    chk("tmo_done_no_pulse", timeout, 0);
    chk("tmo_done_prior", prior, 8'h10);

    // Asynchronous reset mid-BUSY
    man_grant = 8'h08; man_ag = 1'b1;
    tick();
    man_ag = 1'b0; man_grant = 8'h00;
    chk("areset_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_grant_q", grant_q, 8'h00);
    chk("areset_prior", prior, 8'h01);
    chk("areset_owner", owner, 0);
    tick();
    rst_n = 1'b1;

    // ag low: garbage grant ignored
    req = 8'h06; man_grant = 8'h06; man_ag = 1'b0;
    tick();
    chk("noag_busy", busy, 0);
    chk("noag_err", err, 0);

    // Multi-hot grant
    man_ag = 1'b1;
    tick();
    chk("multihot_busy", busy, 0);
    chk("multihot_err", err, 1);
    req = 8'h01; man_grant = 8'h01;
    tick();
    man_ag = 1'b0; man_grant = 8'h00;
    chk("err_sticky_grant_busy", busy, 1);
    chk("err_sticky", err, 1);
    done = 8'h01;
    tick();
    done = 8'h00;
    chk("err_sticky_after_rel", err, 1);

    // Zero grant with ag
    do_reset();
    chk("zero_pre_err", err, 0);
    req = 8'h01; man_grant = 8'h00; man_ag = 1'b1;
    tick();
    chk("zero_busy", busy, 0);
    chk("zero_err", err, 1);

    // Grant not a subset of requests
    do_reset();
    req = 8'h01; man_grant = 8'h10; man_ag = 1'b1;
    tick();
    chk("subset_busy", busy, 0);
    chk("subset_err", err, 1);
    man_ag = 1'b0; man_grant = 8'h00;
    do_reset();

    // Fairness sweep with closed-loop arbiter model
    req = 8'hFF;
    model_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      chk($sformatf("fair%0d_idle", k), busy, 0);
      chk($sformatf("fair%0d_prior", k), prior, exp_g);
      tick();
      chk($sformatf("fair%0d_busy", k), busy, 1);
      chk($sformatf("fair%0d_owner", k), owner, k % 8);
      chk($sformatf("fair%0d_grant_q", k), grant_q, exp_g);
      tick();
      done = exp_g;
      tick();
      done = 8'h00;
      chk($sformatf("fair%0d_rel", k), busy, 0);
      chk($sformatf("fair%0d_tmo", k), timeout, 0);
    end
    model_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Sequential control end of the parallel-prefix round-robin arbiter.
- Owns the one-hot priority vector and drives it into the combinational arbiter.
- Captures the arbiter's grant/any-grant result, then holds the grant for the owning requester until release or timeout.
- Rotates priority to the requester after the released owner, giving fair round-robin across arbitration rounds.

Parameters:
arbiter_width, 8, number of requesters; width of all request/priority/grant vectors
hold_max, 16, maximum BUSY cycles per grant before forced release; 0 disables timeout
owner_w, $clog2(arbiter_width), width of o_owner (derived, not overridden)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_req  input  arbiter_width  requester request lines (also routed to arbiter)
i_done  input  arbiter_width  per-requester release pulse; only owner's bit honoured
i_grant  input  arbiter_width  combinational grant returned by arbiter
i_ag  input  1  any-grant flag returned by arbiter
o_prior  output  arbiter_width  one-hot priority vector to arbiter
o_grant_q  output  arbiter_width  registered, held grant to requesters (one-hot or zero)
o_owner  output  owner_w  binary index of current owner; valid while o_busy=1
o_busy  output  1  a grant is held
o_timeout  output  1  one-cycle pulse on forced release
o_err  output  1  sticky malformed-grant flag

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: o_prior=1 (bit0), o_grant_q=0, o_owner=0, o_busy=0, o_timeout=0, o_err=0, hold counter=0, state=IDLE. Reset mid-BUSY clears everything immediately, without waiting for a clock edge.
- States: IDLE, BUSY. o_busy=1 exactly in BUSY.
- IDLE accept condition: i_ag=1, i_grant one-hot, and (i_grant & i_req)!=0.
- IDLE, condition met: next edge latches o_grant_q=i_grant and o_owner=index(i_grant), clears the counter, goes to BUSY. Grant-to-held latency is 1 cycle.
- IDLE, i_ag=1 but i_grant zero, multi-hot, or not a subset of i_req: stay IDLE, set o_err=1; o_err stays set until reset.
- IDLE, i_ag=0: stay IDLE; i_grant is ignored.
- BUSY: counter increments each cycle; the counter saturates and never wraps. Release occurs on the first cycle in which any of these holds:
  (a) i_done[o_owner]=1;
  (b) i_req[o_owner]=0;
  (c) hold_max!=0 and counter==hold_max-1.
- On release, at the next edge:
  - o_grant_q=0, o_busy=0, state=IDLE;
  - o_prior = o_grant_q rotated left by 1 (owner+1 mod arbiter_width; owner arbiter_width-1 wraps to bit0);
  - o_timeout=1 for one cycle only if (c) held and neither (a) nor (b) did.
- o_prior changes only on release; it is held constant in IDLE and BUSY otherwise.
- Minimum one IDLE cycle between grants; no back-to-back grants.
- While BUSY: i_grant, i_ag, non-owner i_done bits and new requests are ignored.
- o_owner retains its last value in IDLE.
- Counter width: $clog2(hold_max+1), minimum 1.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset: assert i_rst_n=0 mid-cycle with o_busy=1 -> all outputs go to reset values immediately. Deassert -> o_prior=8'h01, o_grant_q=8'h00, o_err=0.
2. Basic grant/release: o_prior=8'h01, i_req=8'h24, i_grant=8'h04, i_ag=1 -> next cycle o_grant_q=8'h04, o_owner=2, o_busy=1. Pulse i_done=8'h04 -> next cycle o_grant_q=8'h00, o_prior=8'h08, o_busy=0.
3. Wrap and request drop: owner=7 (o_grant_q=8'h80). Drop i_req[7] -> next cycle release, o_prior=8'h01, o_timeout=0. Non-owner i_done=8'h01 while BUSY -> no effect.
4. Timeout with hold_max=4: owner=3 holds i_req, no i_done -> after exactly 4 BUSY cycles, release. o_timeout=1 for one cycle, o_prior=8'h10. Repeat with i_done[3] in the 4th cycle -> release with o_timeout=0.
5. Malformed grant: in IDLE, i_ag=1 with i_grant=8'h06 -> stays IDLE, o_err=1 and remains 1 across later valid grants. Same result for i_grant=8'h00, and for i_grant=8'h10 with i_req=8'h01.
6. Fairness sweep: i_req=8'hFF held, ideal arbiter model in loop, each owner releases after 2 cycles -> owners 0,1,...,7,0 in order. Each grant is separated by one IDLE cycle, and o_prior tracks owner+1.
